// File: rtl/pipe_stream_fifo_pkg.sv
// Pipe bus format encodings and field layout helpers.
// Shared by the pipe FIFO and its callers; no ports.
package pipe_stream_fifo_pkg;

    // PipeSpec word: [7:0] data width, [8] start/stop present,
    // [15:12] datasize field width (0 = absent).
    localparam int unsigned PS_d8s = 32'h0000_0108;

    // Pipe word layout: {data, datasize, start, stop, valid, ready}.
    localparam int P_READY_POS   = 0;
    localparam int P_VALID_POS   = 1;
    localparam int P_PAYLOAD_LSB = 2;

    function automatic int p_data_w(input int unsigned ps);
        return int'(ps & 32'h0000_00FF);
    endfunction

    function automatic int p_ss_w(input int unsigned ps);
        return ps[8] ? 2 : 0;
    endfunction

    function automatic int p_datasize_w(input int unsigned ps);
        return int'((ps >> 12) & 32'h0000_000F);
    endfunction

    function automatic int p_payload_w(input int unsigned ps);
        return p_data_w(ps) + p_datasize_w(ps) + p_ss_w(ps);
    endfunction

    // MSB index of the packed pipe word (width is p_m + 1).
    function automatic int p_m(input int unsigned ps);
        return p_payload_w(ps) + 1;
    endfunction

endpackage

// File: rtl/pipe_fifo_mem.sv
// Payload register array: one synchronous write port, one async read port.
// Ports: clk_i, we_i, waddr_i, wdata_i, raddr_i, rdata_o.
module pipe_fifo_mem #(
    parameter int W  = 10,
    parameter int AW = 3
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    localparam int Depth = 1 << AW;

    // Contents are deliberately never reset; the pointers gate visibility.
    logic [W-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pipe_stream_fifo.sv
// First-word-fall-through FIFO between a pipe producer and consumer.
// Ports: clock, reset (sync, active-low), pipe_in, pipe_out (packed pipe words).
module pipe_stream_fifo
    import pipe_stream_fifo_pkg::*;
#(
    parameter int unsigned PipeSpec    = PS_d8s,
    parameter int          MemoryWidth = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    inout  wire  [p_m(PipeSpec):0]  pipe_in,
    inout  wire  [p_m(PipeSpec):0]  pipe_out
);

    localparam int PW = p_payload_w(PipeSpec);
    localparam int PM = p_m(PipeSpec);
    localparam int MW = MemoryWidth;

    logic [MW:0]   wp_q, wp_d;
    logic [MW:0]   rp_q, rp_d;
    logic          empty, full;
    logic          in_valid, in_ready;
    logic          out_valid, out_ready;
    logic          wr_en, rd_en;
    logic [PW-1:0] in_payload;
    logic [PW-1:0] mem_rdata;
    logic [PW-1:0] out_payload;

    // Unpack: producer owns payload/valid, consumer owns ready.
    assign in_valid   = pipe_in[P_VALID_POS];
    assign in_payload = pipe_in[PM:P_PAYLOAD_LSB];
    assign out_ready  = pipe_out[P_READY_POS];

    // Extra pointer MSB separates full from empty when low bits match.
    assign empty = (wp_q == rp_q);
    assign full  = (wp_q[MW-1:0] == rp_q[MW-1:0]) && (wp_q[MW] != rp_q[MW]);

    assign in_ready  = !full;
    assign out_valid = !empty;

    always_comb begin
        wr_en = in_valid && in_ready;
        rd_en = out_valid && out_ready;
        wp_d  = wp_q;
        rp_d  = rp_q;
        if (wr_en) begin
            wp_d = wp_q + 1'b1;
        end
        if (rd_en) begin
            rp_d = rp_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    pipe_fifo_mem #(
        .W  (PW),
        .AW (MW)
    ) u_mem (
        .clk_i   (clock),
        .we_i    (wr_en),
        .waddr_i (wp_q[MW-1:0]),
        .wdata_i (in_payload),
        .raddr_i (rp_q[MW-1:0]),
        .rdata_o (mem_rdata)
    );

    // Stale memory is never exposed: payload is forced to 0 when empty.
    assign out_payload = empty ? '0 : mem_rdata;

    // Pack: this block drives only its own bits of each pipe.
    assign pipe_in[P_READY_POS]         = in_ready;
    assign pipe_out[P_VALID_POS]        = out_valid;
    assign pipe_out[PM:P_PAYLOAD_LSB]   = out_payload;

endmodule

// File: tb/tb_pipe_stream_fifo.sv
// Self-checking bench for pipe_stream_fifo: queue model plus directed cases.
// Pipe word: {data[7:0], start, stop, valid, ready}.
module tb_pipe_stream_fifo;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [9:0]  in_payload;
    wire  [11:0] pipe_in;
    wire  [11:0] pipe_out;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    logic [9:0] q[$];
    bit m_rd, m_wr;

    assign pipe_in[11:1] = {in_payload, in_valid};
    assign pipe_out[0]   = out_ready;

    pipe_stream_fifo dut (
        .clock    (clock),
        .reset    (reset),
        .pipe_in  (pipe_in),
        .pipe_out (pipe_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [9:0] mk(input logic [7:0] d,
                                      input logic s, input logic e);
        return {d, s, e};
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: ordered queue, capacity 8, read and write judged on pre-edge state.
    always @(posedge clock) begin
        if (!reset) begin
            q.delete();
        end else begin
            m_rd = (q.size() > 0) && out_ready;
            m_wr = in_valid && (q.size() < 8);
            if (m_rd) void'(q.pop_front());
            if (m_wr) q.push_back(in_payload);
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("cmp_valid", {31'd0, pipe_out[1]}, {31'd0, q.size() != 0});
            check("cmp_payload", {22'd0, pipe_out[11:2]},
                  {22'd0, (q.size() != 0) ? q[0] : 10'd0});
            check("cmp_in_ready", {31'd0, pipe_in[0]}, {31'd0, q.size() < 8});
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_head(input string name, input logic [9:0] w);
        check(name, {20'd0, pipe_out[11:1]}, {20'd0, w, 1'b1});
    endtask

    task automatic expect_empty(input string name);
        check(name, {20'd0, pipe_out[11:1]}, 32'd0);
    endtask

    initial begin
        reset      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        in_payload = '0;
        step();
        reset  = 1'b1;
        chk_en = 1'b1;
        expect_empty("reset_out");
        check("reset_in_ready", {31'd0, pipe_in[0]}, 32'd1);

        // Single step: write, see it immediately, read on next edge.
        out_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            in_payload = mk(8'(8'h10 + i), 1'(i % 2), (i % 3) != 0);
            in_valid   = 1'b1;
            step();
            in_valid = 1'b0;
            expect_head("single_head", mk(8'(8'h10 + i), 1'(i % 2), (i % 3) != 0));
        end
        step();
        expect_empty("single_drained");

        // Hold: head stays put while out_ready is low.
        for (int i = 0; i < 6; i++) begin
            out_ready  = 1'b0;
            in_payload = mk(8'(8'h30 + i), 1'b1, 1'b0);
            in_valid   = 1'b1;
            step();
            in_valid = 1'b0;
            for (int k = 0; k < 4; k++) begin
                expect_head("hold_stable", mk(8'(8'h30 + i), 1'b1, 1'b0));
                step();
            end
            out_ready = 1'b1;
            step();
            expect_empty("hold_drained");
        end

        // Partial load of 5, then drain; pointers wrap across rounds.
        for (int j = 1; j <= 3; j++) begin
            out_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
                in_payload = mk(8'(8'h10 * j + i), 1'b0, 1'b0);
                in_valid   = 1'b1;
                step();
                expect_head("partial_head", mk(8'(8'h10 * j), 1'b0, 1'b0));
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            for (int i = 0; i < 5; i++) begin
                expect_head("partial_order", mk(8'(8'h10 * j + i), 1'b0, 1'b0));
                step();
            end
            expect_empty("partial_drained");
        end

        // Fill: 18 offers, only the first 8 are taken.
        for (int r = 0; r < 3; r++) begin
            out_ready = 1'b0;
            for (int i = 0; i < 18; i++) begin
                in_payload = mk(8'(8'h40 + r * 8'h20 + i), 1'b0, 1'b1);
                in_valid   = 1'b1;
                step();
                if (i == 6)
                    check("fill_ready_7", {31'd0, pipe_in[0]}, 32'd1);
                if (i == 7)
                    check("fill_ready_8", {31'd0, pipe_in[0]}, 32'd0);
            end
            in_valid = 1'b0;
            expect_head("fill_head", mk(8'(8'h40 + r * 8'h20), 1'b0, 1'b1));
            out_ready = 1'b1;
            for (int i = 0; i < 8; i++) begin
                expect_head("fill_order", mk(8'(8'h40 + r * 8'h20 + i), 1'b0, 1'b1));
                step();
            end
            expect_empty("fill_drained");
        end

        // Simultaneous read and write at half occupancy.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_payload = mk(8'(8'hA0 + i), 1'b1, 1'b1);
            in_valid   = 1'b1;
            step();
        end
        out_ready = 1'b1;
        for (int i = 4; i < 10; i++) begin
            in_payload = mk(8'(8'hA0 + i), 1'b1, 1'b1);
            in_valid   = 1'b1;
            step();
            expect_head("simul_head", mk(8'(8'hA0 + i - 3), 1'b1, 1'b1));
            check("simul_ready", {31'd0, pipe_in[0]}, 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Reset mid-stream discards the 4 stored words.
        reset = 1'b0;
        step();
        reset = 1'b1;
        expect_empty("midreset_out");
        check("midreset_ready", {31'd0, pipe_in[0]}, 32'd1);

        // First write right after reset release.
        in_payload = mk(8'h5A, 1'b1, 1'b0);
        in_valid   = 1'b1;
        step();
        in_valid = 1'b0;
        expect_head("post_reset_head", mk(8'h5A, 1'b1, 1'b0));
        out_ready = 1'b1;
        step();
        expect_empty("post_reset_drained");

        step();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
